// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl
//   Time-multiplexed FIR filter controller. Each accepted sample is written
//   into a TAPS-deep circular history buffer, then TAPS products
//   c[k]*x[n-k] are accumulated through one shared multiplier, one per
//   enabled cycle. The sum is rounded, shifted right by SHIFT and saturated
//   to DW bits.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_en         clock enable; low freezes all state
//   i_valid      input sample offered
//   o_ready      sample can be accepted this cycle (IDLE and enabled)
//   i_data       signed input sample (DW)
//   o_coef_addr  coefficient ROM address (log2 TAPS)
//   i_coef       signed Q1.15 coefficient, valid one cycle after its address
//   o_valid      one-cycle pulse, o_data updated
//   o_data       signed filtered sample (DW)
//   o_busy       high whenever the controller is not IDLE
module fir_mac_ctrl #(
    parameter int TAPS  = 64,
    parameter int DW    = 24,
    parameter int CW    = 16,
    parameter int SHIFT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [DW-1:0]    i_data,
    output logic [$clog2(TAPS)-1:0] o_coef_addr,
    input  logic signed [CW-1:0]    i_coef,
    output logic                    o_valid,
    output logic signed [DW-1:0]    o_data,
    output logic                    o_busy
);

    localparam int AW   = $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACCW-1:0] RND = ACCW'(1) << (SHIFT - 1);

    logic [1:0]             state;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          k;
    logic signed [DW-1:0]   sbuf [TAPS];
    logic signed [DW-1:0]   sample_q;
    logic                   p_valid;
    logic signed [ACCW-1:0] acc;
    logic                   valid_q;
    logic                   en_q;
    logic signed [CW-1:0]   coef_hold;

    logic signed [CW-1:0]   coef_use;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] rounded;
    logic signed [ACCW-1:0] shifted;
    logic signed [DW-1:0]   sat_val;

    // The coefficient for a pending product appears on i_coef in the cycle
    // right after the enabled edge that issued its address. If the next edge
    // is disabled, the ROM may move on to the following address, so that
    // value is captured and used once the enable returns.
    always_comb begin
        coef_use = en_q ? i_coef : coef_hold;
        prod     = PW'(sample_q) * PW'(coef_use);
        rounded  = acc + RND;
        shifted  = rounded >>> SHIFT;
        if (shifted[ACCW-1:DW-1] == {(ACCW-DW+1){shifted[ACCW-1]}})
            sat_val = shifted[DW-1:0];
        else if (shifted[ACCW-1])
            sat_val = {1'b1, {(DW-1){1'b0}}};
        else
            sat_val = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            sample_q  <= '0;
            p_valid   <= 1'b0;
            acc       <= '0;
            valid_q   <= 1'b0;
            en_q      <= 1'b0;
            coef_hold <= '0;
            o_data    <= '0;
            for (int unsigned i = 0; i < TAPS; i++)
                sbuf[i] <= '0;
        end else begin
            en_q    <= i_en;
            if (en_q)
                coef_hold <= i_coef;
            valid_q <= 1'b0;
            if (i_en) begin
                p_valid <= 1'b0;
                if (p_valid)
                    acc <= acc + ACCW'(prod);
                case (state)
                    S_IDLE: begin
                        if (i_valid) begin
                            sbuf[wr_ptr] <= i_data;
                            acc          <= '0;
                            state        <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        sample_q <= sbuf[wr_ptr - k];
                        p_valid  <= 1'b1;
                        if (k == AW'(TAPS - 1)) begin
                            k     <= '0;
                            state <= S_FLUSH;
                        end else begin
                            k <= k + AW'(1);
                        end
                    end
                    S_FLUSH: state <= S_OUT;
                    default: begin
                        o_data  <= sat_val;
                        valid_q <= 1'b1;
                        wr_ptr  <= wr_ptr + AW'(1);
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ready     = (state == S_IDLE) && i_en && !i_rst;
    assign o_valid     = valid_q && i_en;
    assign o_busy      = (state != S_IDLE);
    assign o_coef_addr = k;

endmodule
